// File: rtl/instr_pkg.sv
// instr_pkg: shared fetch/decode widths, constants and fetch-state encoding
package instr_pkg;
   localparam int ADDR_W = 7;
   localparam int INSTR_W = 12;
   localparam logic [ADDR_W-1:0] RESET_PC = 7'd0;
   localparam logic [INSTR_W-1:0] HALT_WORD = 12'hFFF;
   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} fetch_state_t;
endpackage

// File: rtl/program_counter.sv
// program_counter: fetch PC with redirect priority over sequential increment
module program_counter
   import instr_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] pc
);
   // redirect wins over increment; increment wraps naturally at 2^ADDR_W
   always_ff @(posedge clk)
      pc <= rst ? RESET_PC : redirect ? redirect_pc : inc ? pc + 1'b1 : pc;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, instruction register, decode handshake and halt/resume FSM
module instr_fetch
   import instr_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   output logic [ADDR_W-1:0]  imem_adr,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic               resume,
   output logic [INSTR_W-1:0] ir_out,
   output logic [ADDR_W-1:0]  ir_pc,
   output logic               ir_valid,
   input  logic               dec_ready,
   output logic               halted
);
   fetch_state_t state, next_state;
   logic [ADDR_W-1:0] pc;
   logic load, accept;
   assign accept = ir_valid && dec_ready;
   assign load = (state == RUN) && !redirect && (!ir_valid || dec_ready);
   assign imem_adr = pc;
   assign halted = (state == HALTED);
   program_counter u_pc (
      .clk         (clk),
      .rst         (rst),
      .inc         (load),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .pc          (pc)
   );
   // fetch state register
   always_ff @(posedge clk)
      state <= rst ? RUN : next_state;
   // resume leaves HALTED; capturing the halt word enters it
   always_comb
      next_state = (state == HALTED && resume) ? RUN :
                   (load && imem_data == HALT_WORD) ? HALTED : state;
   // instruction register: flush on redirect, capture on load, drain on accept
   always_ff @(posedge clk) begin
      if (rst) begin
         ir_out   <= '0;
         ir_pc    <= '0;
         ir_valid <= 1'b0;
      end else if (redirect) begin
         ir_valid <= 1'b0;
      end else if (load) begin
         ir_out   <= imem_data;
         ir_pc    <= pc;
         ir_valid <= 1'b1;
      end else if (accept) begin
         ir_valid <= 1'b0;
      end
   end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage that sits directly upstream of the 128 x 12-bit instruction memory.
- Owns the program counter and drives the memory address. Captures the combinationally returned instruction word into a fetched-instruction register.
- Hands that word to decode over a valid/ready handshake.
- Supports branch redirect with flush, and a halt/resume state machine.

Parameters:
- ADDR_W, 7, instruction memory address width (128 words).
- INSTR_W, 12, instruction word width.
- RESET_PC, 7'd0, PC value after reset.
- HALT_WORD, 12'hFFF, encoding that halts fetch.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_adr  output  ADDR_W  address to instruction memory; equals pc combinationally.
- imem_data  input  INSTR_W  word from instruction memory; combinational, valid same cycle.
- redirect  input  1  branch/jump taken.
- redirect_pc  input  ADDR_W  target address.
- resume  input  1  leave HALTED state.
- ir_out  output  INSTR_W  fetched instruction to decode.
- ir_pc  output  ADDR_W  address ir_out was fetched from.
- ir_valid  output  1  ir_out holds an unconsumed instruction.
- dec_ready  input  1  decode accepts ir_out this cycle.
- halted  output  1  fetch stopped on HALT_WORD.

Behaviour:
- One clock; reset is synchronous and active-high. On rst: pc=RESET_PC, ir_out=0, ir_pc=0, ir_valid=0, halted=0, state=RUN. rst overrides every other input.
- States are RUN and HALTED. halted=1 exactly when the state is HALTED.
- accept = ir_valid & dec_ready. This is the transfer to decode.
- load = (state==RUN) & !redirect & (!ir_valid | dec_ready).
- On load:
  - ir_out<=imem_data, ir_pc<=pc, ir_valid<=1, pc<=pc+1 (mod 2^ADDR_W, so 127 wraps to 0).
  - Fetch-to-ir_valid latency is 1 cycle. Throughput is 1 instr/cycle while dec_ready is held high.
- accept without load: ir_valid<=0.
- No load and no accept: ir_out, ir_pc and ir_valid hold. ir_out and ir_pc must be stable while ir_valid & !dec_ready.
- Redirect (highest priority below rst):
  - pc<=redirect_pc and ir_valid<=0 (flush). No load occurs that cycle.
  - An accept in the same cycle still counts as consumed by decode.
  - The instruction at redirect_pc appears on ir_out 2 cycles after redirect is asserted, provided dec_ready is high.
- Halt:
  - When load captures imem_data==HALT_WORD, the halt word is still delivered to decode, pc still increments, and the state becomes HALTED next cycle.
  - In HALTED: no loads. A pending ir_valid may still be accepted.
- resume in HALTED: state becomes RUN next cycle and fetch restarts at the current pc.
- resume in RUN: ignored.
- redirect in HALTED: pc updated, flush applied, state stays HALTED unless resume is also asserted. With both asserted, fetch restarts at redirect_pc.
- redirect in the same cycle as an imem_data==HALT_WORD presentation: no load, so no halt.
- imem_adr is purely combinational from pc. No other combinational input-to-output paths exist.

Decomposition:
- Shared package instr_pkg holds ADDR_W, INSTR_W, RESET_PC, HALT_WORD and the fetch-state encoding (RUN=1'b0, HALTED=1'b1). The package is reused by decode.
- One natural sub-module, program_counter: holds pc, with inputs rst, load-increment, redirect and redirect_pc.
- Top level: IR register, handshake and FSM.

Test Plan:
- Streaming: rst, memory preloaded mem[k]=k+12'h100, dec_ready=1 -> ir_out=0x100,0x101,... on consecutive cycles; ir_pc=0,1,2,...; imem_adr leads ir_pc by 1.
- Backpressure: dec_ready=0 for 3 cycles while ir_valid=1 with ir_out=0x105 -> ir_out, ir_pc and pc are frozen; when dec_ready=1 again, 0x105 is accepted once and 0x106 follows.
- Redirect: at pc=10, redirect=1 with redirect_pc=40 -> ir_valid=0 next cycle; ir_pc=40 with ir_out=mem[40] one cycle later; words 10 and 11 are never delivered.
- Wrap: set pc to 126 via redirect and stream -> ir_pc sequence 126,127,0,1.
- Halt/resume: mem[5]=12'hFFF -> ir_out=0xFFF delivered, halted=1, pc=6, no further loads for 5 cycles; resume pulse -> halted=0 and ir_pc=6 appears next.
- Reset mid-stream: rst during backpressure with ir_valid=1 -> next cycle ir_valid=0, ir_out=0, halted=0, imem_adr=RESET_PC.
